// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with stall/bubble/flush,
// deferred flush latch, valid bit and saturating hold/bubble/flush event counters.
module pipe_stage_reg #(
    parameter int ADDR_W = 32,
    parameter int PAYLOAD_W = 96,
    parameter int CTRL_W = 4,
    parameter int HAZ_W = 6,
    parameter logic [PAYLOAD_W-1:0] BUBBLE_PAYLOAD = 'h13,
    parameter int STALL_W = 6,
    parameter int STAGE_IDX = 2,
    parameter bit FLUSH_PRIO = 1,
    parameter bit KEEP_ADDR = 1,
    parameter int CNT_W = 16
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic [STALL_W-1:0]   stall_in,
    input  logic                 jump_flush_in,
    input  logic                 interrupt_flush_in,
    input  logic                 clr_cnt_in,
    input  logic                 valid_in,
    input  logic [ADDR_W-1:0]    addr_in,
    input  logic [PAYLOAD_W-1:0] payload_in,
    input  logic [CTRL_W-1:0]    ctrl_in,
    input  logic [HAZ_W-1:0]     haz_in,
    output logic                 valid_out,
    output logic [ADDR_W-1:0]    addr_out,
    output logic [PAYLOAD_W-1:0] payload_out,
    output logic [CTRL_W-1:0]    ctrl_out,
    output logic [HAZ_W-1:0]     haz_out,
    output logic                 flush_pend_out,
    output logic [CNT_W-1:0]     hold_cnt_out,
    output logic [CNT_W-1:0]     bubble_cnt_out,
    output logic [CNT_W-1:0]     flush_cnt_out
);
    localparam logic [STALL_W-1:0] UP_SEL = STALL_W'(1) << STAGE_IDX;
    localparam logic [STALL_W-1:0] DN_SEL = STALL_W'(1) << (STAGE_IDX + 1);
    logic up, dn, hold, bub, fl_raw, fl;
    logic do_hold, do_flush, do_bub, kill;
    always_comb begin
        up = |(stall_in & UP_SEL);
        dn = |(stall_in & DN_SEL);
        hold = up & dn;
        bub = up & ~dn;
        fl_raw = jump_flush_in | interrupt_flush_in;
        fl = fl_raw | flush_pend_out;
        do_flush = FLUSH_PRIO ? fl : fl & ~hold;
        do_hold = FLUSH_PRIO ? hold & ~fl : hold;
        do_bub = bub & ~fl;
        kill = do_flush | do_bub;
    end
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            valid_out <= 1'b0;
            addr_out <= '0;
            payload_out <= BUBBLE_PAYLOAD;
            ctrl_out <= '0;
            haz_out <= '0;
            flush_pend_out <= 1'b0;
            hold_cnt_out <= '0;
            bubble_cnt_out <= '0;
            flush_cnt_out <= '0;
        end else begin
            // a pending flush survives only while the stage keeps holding
            flush_pend_out <= !FLUSH_PRIO && hold && fl;
            if (kill) begin
                valid_out <= 1'b0;
                addr_out <= KEEP_ADDR ? addr_out : '0;
                payload_out <= BUBBLE_PAYLOAD;
                ctrl_out <= '0;
                haz_out <= '0;
            end else if (!do_hold) begin
                valid_out <= valid_in;
                addr_out <= addr_in;
                payload_out <= payload_in;
                ctrl_out <= ctrl_in;
                haz_out <= haz_in;
            end
            hold_cnt_out <= clr_cnt_in ? '0 : hold_cnt_out + CNT_W'(do_hold & ~&hold_cnt_out);
            bubble_cnt_out <= clr_cnt_in ? '0 : bubble_cnt_out + CNT_W'(do_bub & ~&bubble_cnt_out);
            flush_cnt_out <= clr_cnt_in ? '0 : flush_cnt_out + CNT_W'(do_flush & ~&flush_cnt_out);
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: two instances (flush-priority/keep-addr/16-bit counters and
// hold-priority/clear-addr/4-bit counters) checked against a behavioural model.
module tb_pipe_stage_reg;
    localparam int AW = 32, PW = 96, CW = 4, HW = 6, SW = 6;
    localparam logic [SW-1:0] S_HOLD = 6'b001100, S_BUB = 6'b000100;
    logic clk_in = 1'b0;
    logic reset_in, jump_flush_in, interrupt_flush_in, clr_cnt_in, valid_in;
    logic [SW-1:0] stall_in;
    logic [AW-1:0] addr_in;
    logic [PW-1:0] payload_in;
    logic [CW-1:0] ctrl_in;
    logic [HW-1:0] haz_in;
    logic a_valid, a_pend, b_valid, b_pend;
    logic [AW-1:0] a_addr, b_addr;
    logic [PW-1:0] a_payload, b_payload;
    logic [CW-1:0] a_ctrl, b_ctrl;
    logic [HW-1:0] a_haz, b_haz;
    logic [15:0] a_hold, a_bub, a_flush;
    logic [3:0] b_hold, b_bub, b_flush;
    int tests = 0, fails = 0;
    bit armed = 0;

    always #5 clk_in = ~clk_in;

    pipe_stage_reg #(.FLUSH_PRIO(1), .KEEP_ADDR(1), .CNT_W(16)) u_a (
        .clk_in(clk_in), .reset_in(reset_in), .stall_in(stall_in),
        .jump_flush_in(jump_flush_in), .interrupt_flush_in(interrupt_flush_in),
        .clr_cnt_in(clr_cnt_in), .valid_in(valid_in), .addr_in(addr_in),
        .payload_in(payload_in), .ctrl_in(ctrl_in), .haz_in(haz_in),
        .valid_out(a_valid), .addr_out(a_addr), .payload_out(a_payload),
        .ctrl_out(a_ctrl), .haz_out(a_haz), .flush_pend_out(a_pend),
        .hold_cnt_out(a_hold), .bubble_cnt_out(a_bub), .flush_cnt_out(a_flush));

    pipe_stage_reg #(.FLUSH_PRIO(0), .KEEP_ADDR(0), .CNT_W(4)) u_b (
        .clk_in(clk_in), .reset_in(reset_in), .stall_in(stall_in),
        .jump_flush_in(jump_flush_in), .interrupt_flush_in(interrupt_flush_in),
        .clr_cnt_in(clr_cnt_in), .valid_in(valid_in), .addr_in(addr_in),
        .payload_in(payload_in), .ctrl_in(ctrl_in), .haz_in(haz_in),
        .valid_out(b_valid), .addr_out(b_addr), .payload_out(b_payload),
        .ctrl_out(b_ctrl), .haz_out(b_haz), .flush_pend_out(b_pend),
        .hold_cnt_out(b_hold), .bubble_cnt_out(b_bub), .flush_cnt_out(b_flush));

    typedef struct {
        logic v;
        logic [AW-1:0] a;
        logic [PW-1:0] p;
        logic [CW-1:0] c;
        logic [HW-1:0] h;
        logic pend;
        int unsigned hc, bc, fc;
    } mdl_t;
    mdl_t ma, mb;

    // action: 0 load, 1 hold, 2 bubble, 3 flush, chosen by the priority list
    function automatic mdl_t step_m(mdl_t m, bit fp, bit ka, int unsigned mx);
        mdl_t n = m;
        bit up = stall_in[2], dn = stall_in[3];
        bit f = jump_flush_in || interrupt_flush_in || m.pend;
        int act;
        if (reset_in) begin
            n.v = 0; n.a = 0; n.p = PW'('h13); n.c = 0; n.h = 0; n.pend = 0;
            n.hc = 0; n.bc = 0; n.fc = 0;
            return n;
        end
        if (fp) act = f ? 3 : (up && dn) ? 1 : up ? 2 : 0;
        else act = (up && dn) ? 1 : f ? 3 : up ? 2 : 0;
        n.pend = !fp && act == 1 && f;
        if (act == 0) begin
            n.v = valid_in; n.a = addr_in; n.p = payload_in; n.c = ctrl_in; n.h = haz_in;
        end else if (act >= 2) begin
            n.v = 0; n.a = ka ? m.a : 0; n.p = PW'('h13); n.c = 0; n.h = 0;
        end
        if (act == 1 && m.hc < mx) n.hc = m.hc + 1;
        if (act == 2 && m.bc < mx) n.bc = m.bc + 1;
        if (act == 3 && m.fc < mx) n.fc = m.fc + 1;
        if (clr_cnt_in) begin
            n.hc = 0; n.bc = 0; n.fc = 0;
        end
        return n;
    endfunction

    always @(posedge clk_in) begin
        ma = step_m(ma, 1, 1, 65535);
        mb = step_m(mb, 0, 0, 15);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) if (armed) begin
        chk("a_valid", a_valid, ma.v);
        chk("a_addr", a_addr, ma.a);
        chk("a_payload", a_payload, ma.p);
        chk("a_ctrl", a_ctrl, ma.c);
        chk("a_haz", a_haz, ma.h);
        chk("a_pend", a_pend, 0);
        chk("a_hold_cnt", a_hold, ma.hc);
        chk("a_bubble_cnt", a_bub, ma.bc);
        chk("a_flush_cnt", a_flush, ma.fc);
        chk("b_valid", b_valid, mb.v);
        chk("b_addr", b_addr, mb.a);
        chk("b_payload", b_payload, mb.p);
        chk("b_ctrl", b_ctrl, mb.c);
        chk("b_haz", b_haz, mb.h);
        chk("b_pend", b_pend, mb.pend);
        chk("b_hold_cnt", b_hold, mb.hc);
        chk("b_bubble_cnt", b_bub, mb.bc);
        chk("b_flush_cnt", b_flush, mb.fc);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic drv(input logic [SW-1:0] s, input logic [AW-1:0] a, input logic [PW-1:0] p,
                       input logic [CW-1:0] c, input logic [HW-1:0] h, input logic v);
        stall_in = s; addr_in = a; payload_in = p; ctrl_in = c; haz_in = h; valid_in = v;
    endtask

    initial begin
        reset_in = 1; jump_flush_in = 0; interrupt_flush_in = 0; clr_cnt_in = 0;
        drv('0, '0, '0, '0, '0, 0);
        cyc(2);
        armed = 1;
        chk("lit_reset_payload", a_payload, 'h13);
        chk("lit_reset_valid", b_valid, 0);
        chk("lit_reset_hold", a_hold, 0);
        reset_in = 0;
        drv('0, 'h100, 'hABC, 'hF, 'h25, 1);
        cyc(1);
        chk("lit_load_addr", a_addr, 'h100);
        chk("lit_load_payload", a_payload, 'hABC);
        chk("lit_load_ctrl", a_ctrl, 'hF);
        chk("lit_load_valid", a_valid, 1);
        drv(S_HOLD, 'h200, 'hDEF, '0, '0, 1);
        cyc(3);
        chk("lit_hold_addr", a_addr, 'h100);
        chk("lit_hold_payload", a_payload, 'hABC);
        chk("lit_hold_cnt", a_hold, 3);
        stall_in = S_BUB;
        cyc(1);
        chk("lit_bub_valid", a_valid, 0);
        chk("lit_bub_payload", a_payload, 'h13);
        chk("lit_bub_ctrl", a_ctrl, 0);
        chk("lit_bub_addr_keep", a_addr, 'h100);
        chk("lit_bub_addr_clear", b_addr, 0);
        chk("lit_bub_cnt", a_bub, 1);
        stall_in = S_HOLD; jump_flush_in = 1;
        cyc(1);
        jump_flush_in = 0;
        chk("lit_fp1_flush_cnt", a_flush, 1);
        chk("lit_fp1_hold_cnt", a_hold, 3);
        chk("lit_fp0_pend", b_pend, 1);
        chk("lit_fp0_hold_cnt", b_hold, 4);
        drv('0, 'h300, 'h111, 'h3, 'h5, 1);
        cyc(1);
        chk("lit_pend_taken", b_pend, 0);
        chk("lit_pend_flush_cnt", b_flush, 1);
        chk("lit_pend_valid", b_valid, 0);
        cyc(1);
        stall_in = S_HOLD; interrupt_flush_in = 1;
        cyc(1);
        interrupt_flush_in = 0;
        chk("lit_irq_pend", b_pend, 1);
        chk("lit_irq_held", b_payload, 'h111);
        cyc(1);
        chk("lit_irq_pend2", b_pend, 1);
        chk("lit_irq_addr_held", b_addr, 'h300);
        stall_in = '0;
        cyc(1);
        chk("lit_irq_bubble", b_payload, 'h13);
        chk("lit_irq_pend_clr", b_pend, 0);
        chk("lit_irq_flush_cnt", b_flush, 2);
        chk("lit_irq_addr_clr", b_addr, 0);
        stall_in = S_HOLD;
        cyc(20);
        chk("lit_sat_hold", b_hold, 15);
        clr_cnt_in = 1;
        cyc(1);
        clr_cnt_in = 0;
        chk("lit_clr_b", b_hold, 0);
        chk("lit_clr_a", a_hold, 0);
        jump_flush_in = 1;
        cyc(1);
        jump_flush_in = 0;
        chk("lit_pend_again", b_pend, 1);
        reset_in = 1;
        cyc(1);
        reset_in = 0;
        chk("lit_rst_pend", b_pend, 0);
        chk("lit_rst_hold", b_hold, 0);
        chk("lit_rst_payload", b_payload, 'h13);
        chk("lit_rst_flush", a_flush, 0);
        for (int i = 0; i < 3000; i++) begin
            stall_in = ($urandom_range(0, 9) < 4) ? '0 : SW'($urandom);
            jump_flush_in = ($urandom_range(0, 15) == 0);
            interrupt_flush_in = ($urandom_range(0, 31) == 0);
            clr_cnt_in = ($urandom_range(0, 63) == 0);
            reset_in = ($urandom_range(0, 199) == 0);
            valid_in = 1'($urandom);
            addr_in = $urandom;
            payload_in = {$urandom, $urandom, $urandom};
            ctrl_in = CW'($urandom);
            haz_in = HW'($urandom);
            cyc(1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
